// File: rtl/cam_sensor_sequencer_if.sv
//==== cam_sensor_sequencer_if -- table ROM port and I2C write-master handshake
//==== rev 1.0
`default_nettype none

interface cam_sensor_sequencer_if #(
  parameter int TBL_AW = 8,
  parameter int RA_W   = 16,
  parameter int RD_W   = 8
);
  logic [TBL_AW-1:0]      tbl_addr;
  logic [2+RA_W+RD_W-1:0] tbl_data;
  logic                   wr_req;
  logic [RA_W-1:0]        wr_addr;
  logic [RD_W-1:0]        wr_data;
  logic                   wr_done;
  logic                   wr_nack;

  modport master (
    output tbl_addr, wr_req, wr_addr, wr_data,
    input  tbl_data, wr_done, wr_nack
  );

  modport slave (
    input  tbl_addr, wr_req, wr_addr, wr_data,
    output tbl_data, wr_done, wr_nack
  );
endinterface

`default_nettype wire

// File: rtl/cam_sensor_sequencer.sv
//==== cam_sensor_sequencer -- sensor PWDN/RESETB sequencing and register-table walker
//==== rev 1.0
`default_nettype none

module cam_sensor_sequencer #(
  parameter int T_PWDN     = 5_000_000,
  parameter int T_RESET    = 1_000_000,
  parameter int T_SETTLE   = 10_000_000,
  parameter int TBL_AW     = 8,
  parameter int RA_W       = 16,
  parameter int RD_W       = 8,
  parameter int MAX_RETRY  = 3,
  parameter int RETRY_GAP  = 50_000,
  parameter int DELAY_UNIT = 50_000
) (
  input  logic                  clk,
  input  logic                  rst,
  cam_sensor_sequencer_if.master bus,
  input  logic                  cfg_start_i,
  input  logic                  pwr_down_req_i,
  output logic                  pwdn_o,
  output logic                  resetb_o,
  output logic                  busy_o,
  output logic                  config_done_o,
  output logic                  config_err_o,
  output logic [TBL_AW-1:0]     err_index_o
);

  localparam int C_EW   = 2 + RA_W + RD_W;
  localparam int C_DW   = RA_W + RD_W + $clog2(DELAY_UNIT + 1);
  localparam int C_TM1  = (T_PWDN > T_RESET) ? T_PWDN : T_RESET;
  localparam int C_TM2  = (T_SETTLE > RETRY_GAP) ? T_SETTLE : RETRY_GAP;
  localparam int C_TMAX = (C_TM1 > C_TM2) ? C_TM1 : C_TM2;
  localparam int C_PW   = $clog2(C_TMAX + 1);
  localparam int CW     = (C_DW > C_PW) ? C_DW : C_PW;
  localparam int RW     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CW-1:0] C_PWDN_LAST   = CW'(T_PWDN - 1);
  localparam logic [CW-1:0] C_RESET_LAST  = CW'(T_RESET - 1);
  localparam logic [CW-1:0] C_SETTLE_LAST = CW'(T_SETTLE - 1);
  localparam logic [CW-1:0] C_GAP_LAST    = CW'(RETRY_GAP - 1);
  localparam logic [RW-1:0] C_MAX_RETRY   = RW'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_PWR_OFF    = 4'd0,
    S_WAIT_PWDN  = 4'd1,
    S_WAIT_RESET = 4'd2,
    S_SETTLE     = 4'd3,
    S_FETCH      = 4'd4,
    S_DECODE     = 4'd5,
    S_ISSUE      = 4'd6,
    S_WAIT_ACK   = 4'd7,
    S_RETRY_WAIT = 4'd8,
    S_DELAY      = 4'd9,
    S_DONE       = 4'd10,
    S_ERROR      = 4'd11
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [TBL_AW-1:0]   tbl_addr_q, tbl_addr_d;
  logic                wr_req_q, wr_req_d;
  logic [RA_W-1:0]     wr_addr_q, wr_addr_d;
  logic [RD_W-1:0]     wr_data_q, wr_data_d;
  logic [RW-1:0]       retry_q, retry_d;
  logic                pwdn_q, pwdn_d;
  logic                resetb_q, resetb_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [TBL_AW-1:0]   err_index_q, err_index_d;
  logic                adv;
  logic                go_off;

  logic [1:0]          ent_op;
  logic [RA_W+RD_W-1:0] ent_payload;

  assign ent_op      = bus.tbl_data[C_EW-1 -: 2];
  assign ent_payload = bus.tbl_data[RA_W+RD_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_WAIT_PWDN;
      cnt_q       <= '0;
      tbl_addr_q  <= '0;
      wr_req_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      retry_q     <= '0;
      pwdn_q      <= 1'b1;
      resetb_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_index_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tbl_addr_q  <= tbl_addr_d;
      wr_req_q    <= wr_req_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      retry_q     <= retry_d;
      pwdn_q      <= pwdn_d;
      resetb_q    <= resetb_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_index_q <= err_index_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tbl_addr_d  = tbl_addr_q;
    wr_req_d    = wr_req_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    retry_d     = retry_q;
    pwdn_d      = pwdn_q;
    resetb_d    = resetb_q;
    done_d      = done_q;
    err_d       = err_q;
    err_index_d = err_index_q;
    adv         = 1'b0;
    go_off      = 1'b0;

    case (state_q)
      S_PWR_OFF: begin
        if (!pwr_down_req_i) begin
          state_d    = S_WAIT_PWDN;
          cnt_d      = '0;
          tbl_addr_d = '0;
          retry_d    = '0;
        end
      end
      S_WAIT_PWDN: begin
        if (cnt_q == C_PWDN_LAST) begin
          pwdn_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_WAIT_RESET;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_RESET: begin
        if (cnt_q == C_RESET_LAST) begin
          resetb_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_SETTLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == C_SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (ent_op)
          2'b00: begin
            wr_addr_d = bus.tbl_data[RA_W+RD_W-1:RD_W];
            wr_data_d = bus.tbl_data[RD_W-1:0];
            state_d   = S_ISSUE;
          end
          2'b01: begin
            if (ent_payload == '0) begin
              adv = 1'b1;
            end else begin
              cnt_d   = CW'(ent_payload) * CW'(DELAY_UNIT);
              state_d = S_DELAY;
            end
          end
          default: begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        endcase
      end
      S_ISSUE: begin
        wr_req_d = 1'b1;
        state_d  = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (bus.wr_done) begin
          wr_req_d = 1'b0;
          if (!bus.wr_nack) begin
            retry_d = '0;
            adv     = 1'b1;
          end else if (retry_q < C_MAX_RETRY) begin
            retry_d = retry_q + RW'(1);
            cnt_d   = '0;
            state_d = S_RETRY_WAIT;
          end else begin
            err_index_d = tbl_addr_q;
            err_d       = 1'b1;
            state_d     = S_ERROR;
          end
        end
      end
      // The reissue raises wr_req directly so the idle gap is exactly RETRY_GAP cycles.
      S_RETRY_WAIT: begin
        if (cnt_q == C_GAP_LAST) begin
          wr_req_d = 1'b1;
          state_d  = S_WAIT_ACK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DELAY: begin
        if (cnt_q == CW'(1)) begin
          adv = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE, S_ERROR: begin
        if (cfg_start_i) begin
          done_d     = 1'b0;
          err_d      = 1'b0;
          retry_d    = '0;
          tbl_addr_d = '0;
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_PWR_OFF;
    endcase

    // The last table slot never wraps back to 0; it finishes the run instead.
    if (adv) begin
      if (tbl_addr_q == '1) begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end else begin
        tbl_addr_d = tbl_addr_q + TBL_AW'(1);
        state_d    = S_FETCH;
      end
    end

    go_off = pwr_down_req_i && (state_q != S_PWR_OFF) &&
             ((state_q != S_WAIT_ACK) || bus.wr_done);
    if (go_off) begin
      state_d  = S_PWR_OFF;
      wr_req_d = 1'b0;
      pwdn_d   = 1'b1;
      resetb_d = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
    end
  end

  assign bus.tbl_addr  = tbl_addr_q;
  assign bus.wr_req    = wr_req_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign pwdn_o        = pwdn_q;
  assign resetb_o      = resetb_q;
  assign config_done_o = done_q;
  assign config_err_o  = err_q;
  assign err_index_o   = err_index_q;
  assign busy_o        = !((state_q == S_DONE) || (state_q == S_ERROR) || (state_q == S_PWR_OFF));

endmodule

`default_nettype wire

// File: doc/cam_sensor_sequencer.md
# cam_sensor_sequencer

Parametrised power-up and register-configuration sequencer for CSI camera sensors. It is the generic successor of the fixed OV5647 bring-up controller. It generates the PWDN/RESETB power sequence with configurable delays, then walks an external register table and issues each entry to an SCCB/I2C write master. Over the fixed controller it adds delay entries, NACK retry, error reporting, soft re-configuration and power-down. It sits between the board pins, the sensor register ROM and the I2C master in the video front end.

## Interface
Parameters:
- `T_PWDN`, default 5_000_000: cycles from reset release to PWDN deassert.
- `T_RESET`, default 1_000_000: cycles from PWDN deassert to RESETB release.
- `T_SETTLE`, default 10_000_000: cycles from RESETB release to the first table fetch.
- `TBL_AW`, default 8: table address width.
- `RA_W`, default 16: sensor register address width.
- `RD_W`, default 8: register data width.
- `MAX_RETRY`, default 3: retries after a NACK before error.
- `RETRY_GAP`, default 50_000: idle cycles between retries.
- `DELAY_UNIT`, default 50_000: cycles per delay-entry count.

Ports (clock and reset first):
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_start` in 1: pulse; soft re-configuration from table index 0.
- `pwr_down_req` in 1: level; request sensor power-down.
- `tbl_addr` out TBL_AW: table ROM address.
- `tbl_data` in 2+RA_W+RD_W: entry `{op[1:0], addr, data}`, valid 1 cycle after `tbl_addr`.
- `wr_req` out 1: I2C write request.
- `wr_addr` out RA_W: register address.
- `wr_data` out RD_W: register data.
- `wr_done` in 1: one-cycle pulse, transaction complete.
- `wr_nack` in 1: qualified by `wr_done`; 1 means the sensor NACKed.
- `pwdn` out 1: sensor PWDN, active high.
- `resetb` out 1: sensor RESETB, active low.
- `busy` out 1: sequencer not in DONE, ERROR or PWR_OFF.
- `config_done` out 1: table completed without error.
- `config_err` out 1: retries exhausted.
- `err_index` out TBL_AW: table index of the failing entry.

## Operation
- States: PWR_OFF, WAIT_PWDN, WAIT_RESET, SETTLE, FETCH, DECODE, ISSUE, WAIT_ACK, RETRY_WAIT, DELAY, DONE, ERROR.
- Reset values:
  - `pwdn`=1, `resetb`=0.
  - `wr_req`=0, `busy`=1.
  - `config_done`=0, `config_err`=0.
  - `tbl_addr`=0, `err_index`=0.
  - State is WAIT_PWDN with its counter at 0.
- Power sequence, cycle-counted from the first clock edge after reset release:
  - WAIT_PWDN: after T_PWDN cycles, `pwdn`←0.
  - WAIT_RESET: after T_RESET more cycles, `resetb`←1.
  - SETTLE: after T_SETTLE more cycles, go to FETCH.
- FETCH drives `tbl_addr`. DECODE samples `tbl_data` and dispatches on `op`:
  - 00 write: load `wr_addr`/`wr_data`, go to ISSUE; `wr_req`=1 from the next cycle.
  - 01 delay: count = `{addr,data}`; wait count×DELAY_UNIT cycles, then advance. Count 0 advances with no wait.
  - 10 or 11 end: go to DONE, `config_done`←1.
- Write handshake:
  - `wr_req`, `wr_addr` and `wr_data` hold stable until the `wr_done` cycle. `wr_req` drops the cycle after `wr_done`.
  - ACK: clear the retry counter, `tbl_addr`+1, go to FETCH.
  - NACK with retries used < MAX_RETRY: retry counter +1, go to RETRY_WAIT for RETRY_GAP cycles, then reissue the same entry.
  - NACK with retries used = MAX_RETRY: `err_index`←`tbl_addr`, `config_err`←1, go to ERROR.
  - Total attempts per entry = MAX_RETRY+1.
- Address wrap: an entry processed at `tbl_addr` = 2^TBL_AW−1 that does not itself end is followed by DONE. The address never wraps to 0.
- `cfg_start` in DONE or ERROR:
  - Clears `config_done`, `config_err` and the retry counter; `tbl_addr`←0; goes to FETCH.
  - No power cycle.
  - Ignored in every other state.
- `pwr_down_req`=1:
  - From any state except WAIT_ACK, go to PWR_OFF next cycle.
  - In WAIT_ACK, first wait for `wr_done`, then go to PWR_OFF.
  - PWR_OFF: `pwdn`=1, `resetb`=0, `wr_req`=0, `config_done`=0.
  - On `pwr_down_req` falling, restart at WAIT_PWDN with a full power sequence.
- Simultaneous events:
  - `pwr_down_req` overrides `cfg_start`.
  - `rst` overrides everything.
  - `rst` mid-transaction drops `wr_req` immediately.
- Delay arithmetic: the counter is wide enough for (2^(RA_W+RD_W)−1)×DELAY_UNIT. No overflow saturation is required.

## Timing
- Reset release to `pwdn` fall: T_PWDN cycles. `resetb` rise: T_PWDN+T_RESET. First FETCH: T_PWDN+T_RESET+T_SETTLE.
- Per write entry, excluding I2C time: FETCH(1) + DECODE(1) + ISSUE, then `wr_req` high until `wr_done`. The next FETCH comes 1 cycle after `wr_done`.
- Table ROM latency is exactly 1 cycle; no other latency is tolerated.
- `config_done` and `config_err` are registered and assert the cycle after the deciding event.
- `busy` falls in the same cycle.

## Test plan
Test parameters: T_PWDN=10, T_RESET=5, T_SETTLE=20, RETRY_GAP=8, DELAY_UNIT=4, MAX_RETRY=2.

- Power sequence:
  - Stimulus: release `rst`.
  - Required: `pwdn` falls at cycle 10, `resetb` rises at 15, first `tbl_addr`=0 fetch at 35.
- Table run:
  - Stimulus: 3 writes, then an end entry; the master ACKs each after 6 cycles.
  - Required: three `wr_req` pulses with the correct addr/data; `config_done`=1 after index 3; `busy`=0.
- Delay entry:
  - Stimulus: delay count 5 between two writes.
  - Required: exactly 20 extra cycles between the first `wr_done` and the second FETCH.
  - Stimulus: count 0.
  - Required: no extra wait.
- NACK handling:
  - Stimulus: entry 2 NACKs twice, then ACKs.
  - Required: 3 attempts, each separated by 8 idle cycles; completes normally.
  - Stimulus: entry 2 always NACKs.
  - Required: `config_err`=1, `err_index`=2 after 3 attempts.
- Re-configuration:
  - Stimulus: `cfg_start` in ERROR.
  - Required: `tbl_addr` restarts at 0; `pwdn` and `resetb` unchanged.
  - Stimulus: `cfg_start` during `busy`.
  - Required: ignored.
- Power-down:
  - Stimulus: `pwr_down_req` during WAIT_ACK.
  - Required: PWR_OFF entered only after `wr_done`.
  - Stimulus: release `pwr_down_req`.
  - Required: full power sequence repeats.
  - Stimulus: `pwr_down_req` and `cfg_start` in the same cycle.
  - Required: power-down wins.
